// File: rtl/bist_sequencer_if.sv
// SRAM-side port of the BIST sequencer: registered command strobes out, read data back.
interface bist_sequencer_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int MASK_WIDTH = 2
);
    logic                  we;
    logic                  re;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [MASK_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] dout;

    modport master (output we, re, addr, din, wmask, input dout);
    modport slave  (input we, re, addr, din, wmask, output dout);
endinterface

// File: rtl/bist_sequencer.sv
// BIST controller: runs enabled pattern generators in index order onto one registered
// SRAM port, compares read data at the end of a READ_LATENCY+1 deep pipeline.
module bist_sequencer #(
    parameter int NUM_PATTERNS = 3,
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int MASK_WIDTH   = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               rstb,
    input  logic                               start,
    input  logic [NUM_PATTERNS-1:0]            pattern_en,
    input  logic                               stop_on_fail,
    output logic [NUM_PATTERNS-1:0]            pg_rst,
    output logic [NUM_PATTERNS-1:0]            pg_en,
    input  logic [NUM_PATTERNS*ADDR_WIDTH-1:0] pg_addr,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] pg_data,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] pg_check,
    input  logic [NUM_PATTERNS*MASK_WIDTH-1:0] pg_mask,
    input  logic [NUM_PATTERNS-1:0]            pg_we,
    input  logic [NUM_PATTERNS-1:0]            pg_re,
    input  logic [NUM_PATTERNS-1:0]            pg_done,
    bist_sequencer_if.master                   sram,
    output logic                               busy,
    output logic                               done,
    output logic                               fail,
    output logic [2:0]                         fail_pattern,
    output logic [ADDR_WIDTH-1:0]              fail_addr,
    output logic [DATA_WIDTH-1:0]              fail_expected,
    output logic [DATA_WIDTH-1:0]              fail_actual,
    output logic [15:0]                        error_count
);
    localparam int LAST = READ_LATENCY;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, NEXT, FINISH} state_t;

    state_t                    state, state_nx;
    logic [2:0]                sel, sel_nx;
    logic [NUM_PATTERNS-1:0]   en_q;
    logic                      sof_q;
    logic                      load_cnt;
    logic                      issue;
    logic                      mismatch;

    logic                      cur_we, cur_re, cur_done;
    logic [ADDR_WIDTH-1:0]     cur_addr;
    logic [DATA_WIDTH-1:0]     cur_data, cur_chk;
    logic [MASK_WIDTH-1:0]     cur_mask;

    logic                      has_first, has_next;
    logic [2:0]                first_idx, next_idx;

    logic [LAST:0]                 vld_pipe;
    logic [LAST:0][DATA_WIDTH-1:0] chk_pipe;
    logic [LAST:0][ADDR_WIDTH-1:0] addr_pipe;
    logic [LAST:0][2:0]            pat_pipe;

    always_comb begin
        cur_we   = 1'b0;
        cur_re   = 1'b0;
        cur_done = 1'b0;
        cur_addr = '0;
        cur_data = '0;
        cur_chk  = '0;
        cur_mask = '0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (sel == 3'(i)) begin
                cur_we   = pg_we[i];
                cur_re   = pg_re[i];
                cur_done = pg_done[i];
                cur_addr = pg_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                cur_data = pg_data[i*DATA_WIDTH +: DATA_WIDTH];
                cur_chk  = pg_check[i*DATA_WIDTH +: DATA_WIDTH];
                cur_mask = pg_mask[i*MASK_WIDTH +: MASK_WIDTH];
            end
        end
    end

    // Scanning downward leaves the lowest qualifying index in the result.
    always_comb begin
        has_first = 1'b0;
        first_idx = '0;
        has_next  = 1'b0;
        next_idx  = '0;
        for (int i = NUM_PATTERNS - 1; i >= 0; i--) begin
            if (pattern_en[i]) begin
                has_first = 1'b1;
                first_idx = 3'(i);
            end
            if (en_q[i] && (3'(i) > sel)) begin
                has_next = 1'b1;
                next_idx = 3'(i);
            end
        end
    end

    assign mismatch = vld_pipe[LAST] && (sram.dout != chk_pipe[LAST]);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= IDLE;
            sel      <= '0;
            en_q     <= '0;
            sof_q    <= 1'b0;
            load_cnt <= 1'b0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            load_cnt <= (state == LOAD) ? ~load_cnt : 1'b0;
            if (state == IDLE && start) begin
                en_q  <= pattern_en;
                sof_q <= stop_on_fail;
            end
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        issue    = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (has_first) begin
                    sel_nx   = first_idx;
                    state_nx = LOAD;
                end else begin
                    state_nx = FINISH;
                end
            end
            LOAD: if (load_cnt) state_nx = RUN;
            RUN: begin
                // A stop-on-fail abort also drops the op presented this cycle.
                if (cur_done || (sof_q && mismatch)) state_nx = DRAIN;
                else issue = 1'b1;
            end
            DRAIN: if (vld_pipe == '0) state_nx = NEXT;
            NEXT: begin
                if (sof_q && fail) begin
                    state_nx = FINISH;
                end else if (has_next) begin
                    sel_nx   = next_idx;
                    state_nx = LOAD;
                end else begin
                    state_nx = FINISH;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            pg_rst[i] = !rstb || (state == LOAD && sel == 3'(i));
            pg_en[i]  = (state == RUN) && (sel == 3'(i));
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sram.we    <= 1'b0;
            sram.re    <= 1'b0;
            sram.addr  <= '0;
            sram.din   <= '0;
            sram.wmask <= '0;
        end else begin
            sram.we    <= issue & cur_we;
            sram.re    <= issue & cur_re & ~cur_we;
            sram.addr  <= issue ? cur_addr : '0;
            sram.din   <= issue ? cur_data : '0;
            sram.wmask <= issue ? cur_mask : '0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vld_pipe  <= '0;
            chk_pipe  <= '0;
            addr_pipe <= '0;
            pat_pipe  <= '0;
        end else begin
            vld_pipe[0]  <= issue & cur_re & ~cur_we;
            chk_pipe[0]  <= cur_chk;
            addr_pipe[0] <= cur_addr;
            pat_pipe[0]  <= sel;
            for (int i = 1; i <= LAST; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                chk_pipe[i]  <= chk_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                pat_pipe[i]  <= pat_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_pattern  <= '0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            error_count   <= '0;
        end else if (state == IDLE && start) begin
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_pattern  <= '0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            error_count   <= '0;
        end else begin
            if (mismatch) begin
                if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
                if (!fail) begin
                    fail_pattern  <= pat_pipe[LAST];
                    fail_addr     <= addr_pipe[LAST];
                    fail_expected <= chk_pipe[LAST];
                    fail_actual   <= sram.dout;
                end
                fail <= 1'b1;
            end
            if (state == FINISH) done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboard bench: three scripted generators, a latency-3 SRAM model with an optional
// stuck-at-0 on bit 3 of word 5, and a monitor checking forwarded ops and final status.
module tb_bist_sequencer;
    localparam int NP = 3, AW = 5, DW = 8, MW = 2, RL = 3;

    typedef struct packed {
        logic we; logic re; logic [AW-1:0] addr; logic [DW-1:0] data;
    } op_t;
    typedef struct packed {
        logic fail; logic [2:0] pat; logic [AW-1:0] addr;
        logic [DW-1:0] exp_d; logic [DW-1:0] act_d; logic [15:0] cnt;
    } st_t;

    logic clk = 1'b0, rstb = 1'b0, start = 1'b0, stop_on_fail = 1'b0;
    logic [NP-1:0] pattern_en = '0;
    logic [NP-1:0] pg_rst, pg_en, pg_we, pg_re, pg_done;
    logic [NP*AW-1:0] pg_addr;
    logic [NP*DW-1:0] pg_data, pg_check;
    logic [NP*MW-1:0] pg_mask;
    logic busy, done, fail;
    logic [2:0] fail_pattern;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_expected, fail_actual;
    logic [15:0] error_count;

    bist_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) sram_bus ();

    bist_sequencer #(.NUM_PATTERNS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .MASK_WIDTH(MW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rstb(rstb), .start(start), .pattern_en(pattern_en),
        .stop_on_fail(stop_on_fail), .pg_rst(pg_rst), .pg_en(pg_en),
        .pg_addr(pg_addr), .pg_data(pg_data), .pg_check(pg_check), .pg_mask(pg_mask),
        .pg_we(pg_we), .pg_re(pg_re), .pg_done(pg_done), .sram(sram_bus),
        .busy(busy), .done(done), .fail(fail), .fail_pattern(fail_pattern),
        .fail_addr(fail_addr), .fail_expected(fail_expected), .fail_actual(fail_actual),
        .error_count(error_count)
    );

    always #5 clk = ~clk;

    op_t exp_ops[$];
    st_t exp_st[$];
    int n_cmp = 0, n_bad = 0;
    int step [NP];
    logic fault_on = 1'b0, track_ops = 1'b0, saw_off = 1'b0, done_q = 1'b0;
    logic [NP-1:0] watch_mask = '0;
    int ncyc = 0, last_op = -1, gap_max = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Generator scripts: 0 = zero/one march (128), 1 = checkerboard + write/read collision (65),
    // 2 = all-ones write/read (64).
    function automatic int gen_len(int g);
        return (g == 0) ? 128 : (g == 1) ? 65 : 64;
    endfunction

    function automatic op_t gen_op(int g, int s);
        op_t o = '0;
        int a = s % 32;
        if (s >= gen_len(g)) return o;
        o.addr = AW'(a);
        if (g == 0) begin
            o.we = ((s / 32) % 2) == 0;
            o.re = !o.we;
            o.data = (s >= 64) ? 8'hFF : 8'h00;
        end else if (g == 1) begin
            if (s == 64) begin
                o.we = 1'b1; o.re = 1'b1; o.addr = '0; o.data = 8'hAA;
            end else begin
                o.we = s < 32; o.re = !o.we;
                o.data = (a % 2 == 1) ? 8'h55 : 8'hAA;
            end
        end else begin
            o.we = s < 32; o.re = !o.we; o.data = 8'hFF;
        end
        return o;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < NP; g++) begin
            if (pg_rst[g]) step[g] <= 0;
            else if (pg_en[g] && step[g] < gen_len(g)) step[g] <= step[g] + 1;
        end
    end

    op_t gops [NP];
    always_comb begin
        for (int g = 0; g < NP; g++) gops[g] = gen_op(g, step[g]);
    end

    always_comb begin
        pg_addr = '0; pg_data = '0; pg_check = '0; pg_mask = '0;
        pg_we = '0; pg_re = '0; pg_done = '0;
        for (int g = 0; g < NP; g++) begin
            pg_addr[g*AW +: AW]  = gops[g].addr;
            pg_data[g*DW +: DW]  = gops[g].data;
            pg_check[g*DW +: DW] = gops[g].data;
            pg_mask[g*MW +: MW]  = 2'b11;
            pg_we[g]   = gops[g].we;
            pg_re[g]   = gops[g].re;
            pg_done[g] = step[g] >= gen_len(g);
        end
    end

    // SRAM model: captures the registered command, returns data RL edges later.
    logic [DW-1:0] mem [32];
    logic [DW-1:0] dly [RL];
    logic [DW-1:0] rd;
    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [MW-1:0] m);
        logic [DW-1:0] r = old;
        for (int j = 0; j < MW; j++) if (m[j]) r[j*4 +: 4] = d[j*4 +: 4];
        return r;
    endfunction
    always @(posedge clk) begin
        if (sram_bus.we) mem[sram_bus.addr] <= merge(mem[sram_bus.addr], sram_bus.din, sram_bus.wmask);
        if (sram_bus.re) begin
            rd = mem[sram_bus.addr];
            if (fault_on && sram_bus.addr == 5'd5) rd[3] = 1'b0;
            dly[0] <= rd;
        end
        for (int k = 1; k < RL; k++) dly[k] <= dly[k-1];
    end
    assign sram_bus.dout = dly[RL-1];

    always @(negedge clk) begin
        op_t e;
        st_t s;
        ncyc++;
        if (((pg_en | pg_rst) & watch_mask) != '0) saw_off = 1'b1;
        if (rstb && (sram_bus.we || sram_bus.re)) begin
            if (last_op >= 0 && ncyc - last_op > gap_max) gap_max = ncyc - last_op;
            last_op = ncyc;
            if (track_ops) begin
                if (exp_ops.size() == 0) begin
                    chk("extra_sram_op", {sram_bus.we, sram_bus.re, sram_bus.addr}, 0);
                end else begin
                    e = exp_ops.pop_front();
                    chk("sram_op", {sram_bus.we, sram_bus.re, sram_bus.addr,
                                    (sram_bus.we ? sram_bus.din : 8'h00)}, e);
                end
            end
        end
        if (done && !done_q) begin
            chk("busy_at_done", busy, 0);
            if (exp_st.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                s = exp_st.pop_front();
                chk("status", {fail, fail_pattern, fail_addr, fail_expected, fail_actual, error_count}, s);
            end
        end
        done_q = done;
    end

    task automatic push_run(input logic [2:0] en);
        op_t o;
        for (int g = 0; g < NP; g++) if (en[g]) for (int s = 0; s < gen_len(g); s++) begin
            o = gen_op(g, s);
            o.re = o.re & ~o.we;
            if (!o.we) o.data = 8'h00;
            exp_ops.push_back(o);
        end
    endtask

    task automatic push_st(input logic f, input logic [2:0] p, input logic [AW-1:0] a,
                           input logic [DW-1:0] e, input logic [DW-1:0] x, input logic [15:0] c);
        exp_st.push_back('{f, p, a, e, x, c});
    endtask

    task automatic pulse_start(input logic [2:0] en, input logic sof);
        @(negedge clk);
        last_op = -1; gap_max = 0;
        pattern_en = en; stop_on_fail = sof; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int k);
        k = 1;
        while (!done && k < budget) begin @(negedge clk); k++; end
        chk({name, "_done_reached"}, done, 1);
        @(negedge clk);
    endtask

    task automatic finish_run(input string name);
        chk({name, "_ops_left"}, exp_ops.size(), 0);
        chk({name, "_status_left"}, exp_st.size(), 0);
        exp_ops.delete();
        exp_st.delete();
    endtask

    task automatic check_outs(input string name, input logic [2:0] exp_rst);
        chk({name, "_outputs"}, {pg_en, sram_bus.we, sram_bus.re, sram_bus.addr, sram_bus.din,
            sram_bus.wmask, busy, done, fail, fail_pattern, fail_addr, fail_expected,
            fail_actual, error_count}, 0);
        chk({name, "_pg_rst"}, pg_rst, exp_rst);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check_outs("reset", 3'b111);
        rstb = 1'b1;
        @(negedge clk);
        check_outs("post_reset", 3'b000);

        // Single zero/one generator on ideal memory, plus start-to-first-op latency.
        track_ops = 1'b1;
        push_run(3'b001); push_st(0, 0, 0, 0, 0, 0);
        pulse_start(3'b001, 0);
        k = 1;
        while (!(sram_bus.we || sram_bus.re) && k < 20) begin @(negedge clk); k++; end
        chk("start_to_first_op", k, 4);
        wait_done("single", 400, k);
        chk("single_max_gap", gap_max, 1);
        finish_run("single");

        // Skip generator 1, check switch overhead, and a start while busy is ignored.
        watch_mask = 3'b010; saw_off = 1'b0;
        push_run(3'b101); push_st(0, 0, 0, 0, 0, 0);
        pulse_start(3'b101, 0);
        repeat (30) @(negedge clk);
        pattern_en = 3'b010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("skip", 600, k);
        watch_mask = '0;
        chk("skip_gen1_untouched", saw_off, 0);
        chk("skip_switch_gap", gap_max, RL + 6);
        finish_run("skip");

        // All three, including the write/read collision op.
        push_run(3'b111); push_st(0, 0, 0, 0, 0, 0);
        pulse_start(3'b111, 0);
        wait_done("all", 800, k);
        finish_run("all");

        // Stuck-at fault, keep running.
        fault_on = 1'b1;
        push_run(3'b011); push_st(1, 0, 5, 8'hFF, 8'hF7, 1);
        pulse_start(3'b011, 0);
        wait_done("fault", 800, k);
        finish_run("fault");

        // Same fault with stop_on_fail: later generators never touched.
        track_ops = 1'b0; watch_mask = 3'b110; saw_off = 1'b0;
        push_st(1, 0, 5, 8'hFF, 8'hF7, 1);
        pulse_start(3'b111, 1);
        k = 0;
        while (!fail && k < 400) begin @(negedge clk); k++; end
        chk("sof_fail_seen", fail, 1);
        k = 0;
        while (!done && k < 20) begin @(negedge clk); k++; end
        chk("sof_fail_to_done_within_bound", (k <= RL + 3), 1);
        @(negedge clk);
        watch_mask = '0;
        chk("sof_later_gens_untouched", saw_off, 0);
        finish_run("sof");

        // Fault seen by generator 2 alone.
        track_ops = 1'b1;
        push_run(3'b100); push_st(1, 2, 5, 8'hFF, 8'hF7, 1);
        pulse_start(3'b100, 0);
        wait_done("gen2_fault", 400, k);
        finish_run("gen2_fault");

        // Nothing enabled: status cleared, done quickly.
        push_st(0, 0, 0, 0, 0, 0);
        pulse_start(3'b000, 0);
        k = 1;
        while (!done && k < 10) begin @(negedge clk); k++; end
        chk("empty_done_latency", (k <= 2), 1);
        @(negedge clk);
        finish_run("empty");

        // Reset in the middle of a run, then a clean rerun.
        fault_on = 1'b0; track_ops = 1'b0;
        pulse_start(3'b111, 0);
        repeat (40) @(negedge clk);
        rstb = 1'b0;
        #1 check_outs("midrun_reset", 3'b111);
        @(negedge clk);
        rstb = 1'b1;
        #1 check_outs("after_midrun_reset", 3'b000);
        track_ops = 1'b1;
        push_run(3'b111); push_st(0, 0, 0, 0, 0, 0);
        pulse_start(3'b111, 0);
        wait_done("rerun", 800, k);
        finish_run("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
